// File: rtl/ram_dual_lane.sv
// ram_dual_lane: word-write / lane-read RAM with a per-word "written" bitmap.
//
// Storage is 2**DEPTH words of WIDTH bits. Each word splits into RATIO lanes of
// LW = WIDTH/RATIO bits, and lane 0 is the most significant slice.
// Writes are per-lane masked. Reads return one lane per request.
// A read and a write to the same word in the same cycle are write-first.
//
// Ports:
//   clk           rising-edge system clock
//   reset_n       asynchronous active-low reset (storage array is not reset)
//   wr_en         write request
//   wr_lane_en    per-lane write enable, bit i -> lane i
//   wr_addr       write word address
//   din           write data, full word
//   rd_en         read request, one per cycle, no bubbles
//   rd_addr       {word, lane} read address
//   dout          read lane data, held between reads
//   rd_valid      one-cycle pulse per completed read (latency 1 + OUT_REG)
//   rd_unwritten  word read has not been written since reset (with rd_valid)
module ram_dual_lane #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 8,
  parameter int RATIO   = 2,
  parameter int OUT_REG = 0,
  localparam int LW     = WIDTH / RATIO,
  localparam int LR     = $clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [RATIO-1:0]      wr_lane_en,
  input  logic [DEPTH-1:0]      wr_addr,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  input  logic [DEPTH+LR-1:0]   rd_addr,
  output logic [LW-1:0]         dout,
  output logic                  rd_valid,
  output logic                  rd_unwritten
);

  localparam int LRW = (LR > 0) ? LR : 1;

  logic [WIDTH-1:0]      mem [2**DEPTH];
  logic [2**DEPTH-1:0]   written;

  logic [DEPTH-1:0]      rd_word;
  logic [LRW-1:0]        rd_lane;
  logic [WIDTH-1:0]      merged;
  logic [LW-1:0]         lane_data;
  logic                  wr_any;
  logic                  wr_hit;

  logic                  s1_valid;
  logic [LW-1:0]         s1_data;
  logic                  s1_unw;

  assign rd_word = rd_addr[DEPTH+LR-1:LR];

  if (LR > 0) begin : g_lane
    assign rd_lane = rd_addr[LRW-1:0];
  end else begin : g_nolane
    assign rd_lane = '0;
  end

  assign wr_any = wr_en && (|wr_lane_en);
  assign wr_hit = wr_any && (wr_addr == rd_word);

  // Storage: no reset; writes are suppressed while reset_n is low.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (wr_lane_en[i])
          mem[wr_addr][WIDTH-1-i*LW -: LW] <= din[WIDTH-1-i*LW -: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      written <= '0;
    else if (wr_any)
      written[wr_addr] <= 1'b1;
  end

  // Write-first bypass: enabled lanes of a same-word write replace the stored
  // slices before the requested lane is selected.
  always_comb begin
    merged    = mem[rd_word];
    lane_data = '0;
    if (wr_en && (wr_addr == rd_word)) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (wr_lane_en[i])
          merged[WIDTH-1-i*LW -: LW] = din[WIDTH-1-i*LW -: LW];
      end
    end
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (rd_lane == LRW'(k))
        lane_data = merged[WIDTH-1-k*LW -: LW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_unw   <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_data <= lane_data;
        s1_unw  <= !(written[rd_word] || wr_hit);
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic          s2_valid;
    logic [LW-1:0] s2_data;
    logic          s2_unw;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
        s2_unw   <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
          s2_unw  <= s1_unw;
        end
      end
    end

    assign dout         = s2_data;
    assign rd_valid     = s2_valid;
    assign rd_unwritten = s2_unw;
  end else begin : g_direct
    assign dout         = s1_data;
    assign rd_valid     = s1_valid;
    assign rd_unwritten = s1_unw;
  end

endmodule

// File: tb/tb_ram_dual_lane.sv
// Bench for ram_dual_lane: two instances (OUT_REG=0 and OUT_REG=1) share one
// stimulus stream. Every issued read pushes its expected result into one queue per
// instance. Each instance's monitor pops from its queue on rd_valid and checks the
// data, rd_unwritten and latency.
module tb_ram_dual_lane;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [1:0] wr_lane_en;
  logic [3:0] wr_addr;
  logic [7:0] din;
  logic       rd_en;
  logic [4:0] rd_addr;

  logic [3:0] dout0, dout1;
  logic       rd_valid0, rd_valid1;
  logic       rd_unw0, rd_unw1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] data;
    logic       unw;
    bit         chk_data;
    int         acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_dual_lane #(.DEPTH(4), .WIDTH(8), .RATIO(2), .OUT_REG(0)) u0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_lane_en(wr_lane_en),
    .wr_addr(wr_addr), .din(din), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout(dout0), .rd_valid(rd_valid0), .rd_unwritten(rd_unw0)
  );

  ram_dual_lane #(.DEPTH(4), .WIDTH(8), .RATIO(2), .OUT_REG(1)) u1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_lane_en(wr_lane_en),
    .wr_addr(wr_addr), .din(din), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout(dout1), .rd_valid(rd_valid1), .rd_unwritten(rd_unw1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rd_valid0 === 1'b1) begin
      chk("u0 expected read pending", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        chk("u0 latency", 32'(cyc), 32'(e.acc));
        chk("u0 rd_unwritten", 32'(rd_unw0), 32'(e.unw));
        if (e.chk_data) chk("u0 dout", 32'(dout0), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid1 === 1'b1) begin
      chk("u1 expected read pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("u1 latency", 32'(cyc), 32'(e.acc + 1));
        chk("u1 rd_unwritten", 32'(rd_unw1), 32'(e.unw));
        if (e.chk_data) chk("u1 dout", 32'(dout1), 32'(e.data));
      end
    end
  end

  // Called at a falling edge: sets inputs for the next rising edge, then waits
  // one cycle.
  task automatic drive(input logic we, input logic [1:0] le, input logic [3:0] wa,
                       input logic [7:0] d, input logic re, input logic [4:0] ra,
                       input logic [3:0] ed, input logic eu, input bit cd);
    exp_t e;
    wr_en = we; wr_lane_en = le; wr_addr = wa; din = d;
    rd_en = re; rd_addr = ra;
    if (re) begin
      e.data = ed; e.unw = eu; e.chk_data = cd; e.acc = cyc + 1;
      q0.push_back(e);
      q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [7:0] d, input logic [1:0] le);
    drive(1'b1, le, wa, d, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] ra, input logic [3:0] ed, input logic eu, input bit cd);
    drive(1'b0, 2'b00, 4'd0, 8'h00, 1'b1, ra, ed, eu, cd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " u0 dout"}, 32'(dout0), 32'd0);
    chk({tag, " u0 rd_valid"}, 32'(rd_valid0), 32'd0);
    chk({tag, " u0 rd_unwritten"}, 32'(rd_unw0), 32'd0);
    chk({tag, " u1 dout"}, 32'(dout1), 32'd0);
    chk({tag, " u1 rd_valid"}, 32'(rd_valid1), 32'd0);
    chk({tag, " u1 rd_unwritten"}, 32'(rd_unw1), 32'd0);
  endtask

  // Reset lands while a read is in flight. Writes and reads held during reset
  // must leave no trace.
  task automatic mid_reset();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd10;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_outputs_zero("async reset");
    q0.delete();
    q1.delete();
    wr_en = 1'b1; wr_lane_en = 2'b11; wr_addr = 4'd0; din = 8'h55;
    rd_en = 1'b1; rd_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; wr_lane_en = 2'b00; rd_en = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_lane_en = 2'b00; wr_addr = '0; din = '0;
    rd_en = 1'b0; rd_addr = '0;
    #7 chk_outputs_zero("reset state");
    @(negedge clk);
    reset_n = 1'b1;

    // Read on the first edge after release: word 15 lane 1, never written.
    rd(5'd31, 4'h0, 1'b1, 1'b0);
    wr(4'd15, 8'h0F, 2'b11);
    rd(5'd31, 4'hF, 1'b0, 1'b1);
    rd(5'd30, 4'h0, 1'b0, 1'b1);

    // Full write and lane reads, MSB-first lanes.
    wr(4'd3, 8'hA5, 2'b11);
    rd(5'd6, 4'hA, 1'b0, 1'b1);
    rd(5'd7, 4'h5, 1'b0, 1'b1);

    // Partial write: lane 1 only (low nibble).
    wr(4'd3, 8'h3C, 2'b10);
    rd(5'd6, 4'hA, 1'b0, 1'b1);
    rd(5'd7, 4'hC, 1'b0, 1'b1);

    // Same-edge write and read to the same word (write-first).
    drive(1'b1, 2'b11, 4'd5, 8'h7E, 1'b1, 5'd10, 4'h7, 1'b0, 1'b1);
    // Lane-disabled write to a fresh word: still unwritten, now and later.
    drive(1'b1, 2'b00, 4'd6, 8'h7E, 1'b1, 5'd12, 4'h0, 1'b1, 1'b0);
    rd(5'd13, 4'h0, 1'b1, 1'b0);
    // Partial same-word write: lane 0 bypassed, lane 1 from storage.
    drive(1'b1, 2'b01, 4'd5, 8'h9B, 1'b1, 5'd11, 4'hE, 1'b0, 1'b1);
    drive(1'b1, 2'b10, 4'd5, 8'h42, 1'b1, 5'd10, 4'h9, 1'b0, 1'b1);
    rd(5'd11, 4'h2, 1'b0, 1'b1);
    // Different words in the same cycle are independent.
    drive(1'b1, 2'b11, 4'd7, 8'h11, 1'b1, 5'd6, 4'hA, 1'b0, 1'b1);
    rd(5'd14, 4'h1, 1'b0, 1'b1);
    idle(3);

    // Streaming sweep: word w holds {w, 15-w}.
    for (int w = 0; w < 16; w++) wr(4'(w), {4'(w), 4'(15 - w)}, 2'b11);
    for (int a = 0; a < 32; a++)
      rd(5'(a), (a % 2 == 0) ? 4'(a / 2) : 4'(15 - a / 2), 1'b0, 1'b1);
    idle(3);

    // Second sweep, interrupted by reset part-way.
    for (int a = 0; a < 10; a++)
      rd(5'(a), (a % 2 == 0) ? 4'(a / 2) : 4'(15 - a / 2), 1'b0, 1'b1);
    mid_reset();
    for (int a = 0; a < 32; a++) rd(5'(a), 4'h0, 1'b1, 1'b0);
    idle(4);

    chk("u0 all reads completed", 32'(q0.size()), 32'd0);
    chk("u1 all reads completed", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
